// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver driven by a 1-clk tick at OVERSAMPLE x baud.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN;
// without it the frame is start + DATA_BITS + stop and parity_err is tied low.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 parity_err
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS + 1);
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_END  = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rxs;
  logic [SCW-1:0]       sc, sc_n;
  logic [BIW-1:0]       bi, bi_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 dv_n, fe_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_n, pe_n;
`endif

  // two-flop synchroniser, idles high so reset does not look like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  end
  assign rxs = sync[1];

  // next-state, counters and output pulses; everything advances only on tick
  always_comb begin
    state_n = state;
    sc_n    = sc;
    bi_n    = bi;
    sh_n    = sh;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bad;
    pe_n    = 1'b0;
`endif
    if (tick) begin
      case (state)
        IDLE: if (!rxs) begin
          state_n = START;
          sc_n    = '0;
        end
        START: if (sc == SC_MID) begin
          sc_n = '0;
          bi_n = '0;
          // a start bit that is gone by its midpoint was a glitch
          state_n = rxs ? IDLE : DATA;
        end else sc_n = sc + 1'b1;
        DATA: if (sc == SC_END) begin
          sc_n = '0;
          sh_n = {rxs, sh[DATA_BITS-1:1]};
          bi_n = bi + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bi == BI_LAST) state_n = PARITY;
`else
          if (bi == BI_LAST) state_n = STOP;
`endif
        end else sc_n = sc + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (sc == SC_END) begin
          sc_n    = '0;
          par_n   = (^sh) ^ rxs;
          state_n = STOP;
        end else sc_n = sc + 1'b1;
`endif
        STOP: if (sc == SC_END) begin
          sc_n = '0;
          if (rxs) begin
            dv_n    = 1'b1;
`ifdef UART_RX_PARITY_EN
            pe_n    = par_bad;
`endif
            state_n = IDLE;
          end else begin
            // only one framing error per held-low line: wait in BREAK for idle
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end else sc_n = sc + 1'b1;
        BREAK: if (rxs) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sc    <= '0;
      bi    <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      bi    <= bi_n;
      sh    <= sh_n;
    end
  end

  // registered result pulses; data_out only moves with data_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      data_valid  <= dv_n;
      framing_err <= fe_n;
      if (dv_n) data_out <= sh;
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity verdict held from the parity sample until the stop sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_n;
      parity_err <= pe_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx with tick every 4 clk, 16x oversampling, 8 data bits.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid, framing_err, parity_err;
  logic [1:0] tphase = 2'd0;

  int total = 0;
  int bad   = 0;
  int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, excl = 0;
  logic [7:0] rxq[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rxd(rxd),
    .data_out(data_out), .data_valid(data_valid),
    .framing_err(framing_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // tick generator: one clk in four
  always @(posedge clk) tphase <= tphase + 2'd1;
  assign tick = (tphase == 2'd3);

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      rxq.push_back(data_out);
    end
    if (framing_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if (framing_err && (data_valid || parity_err)) excl++;
    if (parity_err && !data_valid) excl++;
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ flip_par);
`else
    if (flip_par) rxd = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (data_out !== 8'h00) begin
      $display("FAIL reset_data got=%h exp=00", data_out); bad++;
    end
    total++;
    if ({data_valid, framing_err, parity_err} !== 3'b000) begin
      $display("FAIL reset_flags got=%b exp=000", {data_valid, framing_err, parity_err}); bad++;
    end
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_single;
    int d0 = dv_cnt, f0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    total++;
    if (dv_cnt - d0 !== 1) begin
      $display("FAIL single_count got=%0d exp=1", dv_cnt - d0); bad++;
    end
    total++;
    if (data_out !== 8'hA5) begin
      $display("FAIL single_data got=%h exp=a5", data_out); bad++;
    end
    total++;
    if (fe_cnt !== f0) begin
      $display("FAIL single_ferr got=%0d exp=%0d", fe_cnt, f0); bad++;
    end
  endtask

  task automatic test_false_start;
    int d0 = dv_cnt, f0 = fe_cnt;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    idle(100);
    total++;
    if ((dv_cnt - d0) + (fe_cnt - f0) !== 0) begin
      $display("FAIL false_start_pulses got=%0d exp=0", (dv_cnt - d0) + (fe_cnt - f0)); bad++;
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    total++;
    if (dv_cnt - d0 !== 1 || data_out !== 8'h3C) begin
      $display("FAIL false_start_next got=%h cnt=%0d exp=3c cnt=1", data_out, dv_cnt - d0); bad++;
    end
  endtask

  task automatic test_framing;
    int d0 = dv_cnt, f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (160) @(negedge clk);
    idle(100);
    total++;
    if (fe_cnt - f0 !== 1) begin
      $display("FAIL framing_count got=%0d exp=1", fe_cnt - f0); bad++;
    end
    total++;
    if (dv_cnt !== d0 || data_out !== 8'h3C) begin
      $display("FAIL framing_no_data got=%h cnt=%0d exp=3c cnt=0", data_out, dv_cnt - d0); bad++;
    end
    send_frame(8'h12, 1'b1, 1'b0);
    idle(20);
    total++;
    if (dv_cnt - d0 !== 1 || data_out !== 8'h12) begin
      $display("FAIL framing_next got=%h cnt=%0d exp=12 cnt=1", data_out, dv_cnt - d0); bad++;
    end
  endtask

  task automatic test_back_to_back;
    int n0 = rxq.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    total++;
    if (rxq.size() - n0 !== 3) begin
      $display("FAIL b2b_count got=%0d exp=3", rxq.size() - n0); bad++;
    end else begin
      total++;
      if ({rxq[n0], rxq[n0+1], rxq[n0+2]} !== 24'h00FF81) begin
        $display("FAIL b2b_data got=%h %h %h exp=00 ff 81", rxq[n0], rxq[n0+1], rxq[n0+2]); bad++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int d0 = dv_cnt, f0 = fe_cnt;
    logic [7:0] d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rxd = d[3];
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({data_out, data_valid, framing_err, parity_err} !== 11'd0) begin
      $display("FAIL rst_mid_outputs got=%h %b%b%b exp=00 000", data_out, data_valid, framing_err, parity_err); bad++;
    end
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    rst = 1'b0;
    idle(300);
    total++;
    if (dv_cnt !== d0 || fe_cnt !== f0) begin
      $display("FAIL rst_mid_pulses got=%0d/%0d exp=0/0", dv_cnt - d0, fe_cnt - f0); bad++;
    end
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(20);
    total++;
    if (dv_cnt - d0 !== 1 || data_out !== 8'h7E) begin
      $display("FAIL rst_mid_next got=%h cnt=%0d exp=7e cnt=1", data_out, dv_cnt - d0); bad++;
    end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int d0 = dv_cnt, p0 = pe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    total++;
    if (dv_cnt - d0 !== 1 || pe_cnt !== p0) begin
      $display("FAIL parity_good got=dv%0d pe%0d exp=dv1 pe0", dv_cnt - d0, pe_cnt - p0); bad++;
    end
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    total++;
    if (dv_cnt - d0 !== 2 || pe_cnt - p0 !== 1 || data_out !== 8'hA5) begin
      $display("FAIL parity_bad got=dv%0d pe%0d %h exp=dv2 pe1 a5", dv_cnt - d0, pe_cnt - p0, data_out); bad++;
    end
`else
    total++;
    if (pe_cnt !== 0) begin
      $display("FAIL parity_tied got=%0d exp=0", pe_cnt); bad++;
    end
`endif
  endtask

  task automatic test_exclusive;
    total++;
    if (excl !== 0) begin
      $display("FAIL pulse_exclusive got=%0d exp=0", excl); bad++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver. It consumes the 16x baud enable pulse from the baud rate generator and deserialises the asynchronous `rxd` line into parallel bytes. It sits between the pad-side serial input and the host-side byte consumer. It reports each received byte with a one-cycle valid pulse, plus framing and (optionally) parity error flags.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `OVERSAMPLE`, default 16: ticks per bit period. Must be even and ≥ 4.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `tick` input, 1 bit: oversample enable. A one-`clk`-wide pulse from the baud generator, at OVERSAMPLE × baud.
- `rxd` input, 1 bit: asynchronous serial line. Idle high.
- `data_out` output, DATA_BITS: last received byte, LSB = first bit on the line.
- `data_valid` output, 1 bit: one-cycle pulse when `data_out` is updated.
- `framing_err` output, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `parity_err` output, 1 bit: one-cycle pulse on parity mismatch. Constant 0 when parity is compiled out.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops, both reset to 1. All decisions use the synchronised value `rxs`.
- **Counters:**
  - Tick counter `sc`, width clog2(OVERSAMPLE).
  - Bit index `bi`, width clog2(DATA_BITS+1).
  - Shift register `sh`, DATA_BITS wide, shifts right with the new bit entering at the MSB.
  - Counters advance only on cycles where `tick`=1.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
- **IDLE:** on `tick` with `rxs`=0 → START, `sc`=0.
- **START:** each tick increments `sc`. On the tick where `sc`=OVERSAMPLE/2−1 (mid start bit):
  - If `rxs`=0 → DATA, with `sc`=0 and `bi`=0.
  - If `rxs`=1, the start was false → IDLE. No output is asserted.
- **DATA:** on the tick where `sc`=OVERSAMPLE−1 (mid bit), shift `rxs` into `sh`, set `sc`=0 and increment `bi`. After the DATA_BITS-th sample → PARITY if the macro is defined, otherwise → STOP.
- **PARITY:** sample at `sc`=OVERSAMPLE−1, then → STOP. The sampled bit is latched in a `par_bad` flag, computed as even parity: XOR of data bits and the parity bit ≠ 0.
- **STOP:** sample at `sc`=OVERSAMPLE−1.
  - If `rxs`=1: load `data_out`←`sh`, pulse `data_valid`, pulse `parity_err` if `par_bad` is set, → IDLE.
  - If `rxs`=0: pulse `framing_err`. `data_out` is not updated and `data_valid` is not pulsed. → BREAK.
- **BREAK:** remain until `tick` with `rxs`=1, then → IDLE. A held-low line therefore produces exactly one `framing_err`.
- **No re-sync mid-frame:** `rxd` edges during DATA, PARITY or STOP are ignored except at the sample points.
- **`tick` held high:** legal. Every clock is then treated as an oversample tick.

## Timing
- **Reset values:** state IDLE, `sc`=0, `bi`=0, `sh`=0, `data_out`=0, `data_valid`=0, `framing_err`=0, `parity_err`=0, synchroniser flops=1.
- **Reset mid-frame:** the partial frame is discarded. No pulses are produced, and reception resumes at the next falling edge after reset is released.
- **Input latency:** 2 `clk` from a `rxd` change to `rxs`.
- **Output latency:** `data_valid`, `framing_err` and `parity_err` are registered. They assert in the cycle after the `clk` edge on which the stop-bit tick is sampled, last exactly 1 `clk`, and are mutually exclusive except `parity_err` with `data_valid`.
- **`data_out`:** changes only together with `data_valid`, and is held stable until the next valid frame.
- **Frame length:** from the detected start edge to the STOP sample is OVERSAMPLE/2 + (DATA_BITS+1[+1 with parity]) × OVERSAMPLE ticks.
- **Back-to-back frames:** supported. A start edge seen on the first IDLE tick after STOP is accepted.

## Configuration
- **`UART_RX_PARITY_EN`**
  - **Defined:** the PARITY state exists and one even-parity bit is expected between the data and stop bits. `parity_err` pulses together with `data_valid` on mismatch. `data_out` is still delivered.
  - **Undefined:** there is no PARITY state, the frame is start + DATA_BITS + stop, and `parity_err` is tied to 0.

## Test plan
All scenarios use `tick` every 4 `clk`, OVERSAMPLE=16 and DATA_BITS=8.
- **Single byte:** send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) → one `data_valid` pulse with `data_out`=0xA5; `framing_err`=0.
- **False start:** drive `rxd` low for 4 ticks, then high → no `data_valid` or `framing_err`, FSM back in IDLE, and a following 0x3C frame is received correctly.
- **Framing error:** send 0x55 with the stop bit low, hold `rxd` low for 40 ticks, then release → exactly one `framing_err` pulse, no `data_valid`, `data_out` unchanged; the next frame 0x12 is received.
- **Back-to-back:** send 0x00, 0xFF, 0x81 with no idle gap → three `data_valid` pulses carrying 0x00, 0xFF, 0x81 in order.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xC3 → all outputs go to 0 immediately; no pulse after release; the next 0x7E is received.
- **Parity (`UART_RX_PARITY_EN`):** send 0xA5 with parity bit 0 → `data_valid`, `parity_err`=0. Send 0xA5 with parity bit 1 → `data_valid` and `parity_err` pulse together, `data_out`=0xA5.
